// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a level valid/ack handshake.
// Define UART_RX_PARITY_EN to expect an even parity bit between data and stop.
module uart_rx #(
  parameter  int CLKS_PER_BIT = 868,
  localparam int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  input  logic       ack,
  output logic [7:0] data,
  output logic       valid,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err
);

  localparam logic [CNT_W-1:0] HALF = CNT_W'(CLKS_PER_BIT/2 - 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state, state_n;
  logic [1:0]       sync;
  logic             rx_s;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [2:0]       bit_idx, bit_n;
  logic [7:0]       shift, shift_n, data_n;
  logic             valid_n, ovr_n, ferr_n, perr_n;
  logic             pbad;

  assign rx_s = sync[1];
  assign busy = (state != IDLE) && (state != WAIT_IDLE);

`ifdef UART_RX_PARITY_EN
  logic pbad_n, perr;
  assign parity_err = perr;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      pbad <= 1'b0;
      perr <= 1'b0;
    end else begin
      pbad <= pbad_n;
      perr <= perr_n;
    end
`else
  assign pbad       = 1'b0;
  assign parity_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      sync      <= 2'b11;
      state     <= WAIT_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync      <= {sync[0], rx};
      state     <= state_n;
      cnt       <= cnt_n;
      bit_idx   <= bit_n;
      shift     <= shift_n;
      data      <= data_n;
      valid     <= valid_n;
      overrun   <= ovr_n;
      frame_err <= ferr_n;
    end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shift_n = shift;
    data_n  = data;
    valid_n = valid;
    ovr_n   = overrun;
    ferr_n  = 1'b0;
    perr_n  = 1'b0;
`ifdef UART_RX_PARITY_EN
    pbad_n  = pbad;
`endif
    if (ack) begin
      valid_n = 1'b0;
      ovr_n   = 1'b0;
    end
    case (state)
      WAIT_IDLE: if (rx_s) state_n = IDLE;
      IDLE: if (!rx_s) begin
        cnt_n   = '0;
        state_n = START;
      end
      START: if (cnt == HALF) begin
        // a line back high at mid-start was noise, not a frame
        cnt_n   = '0;
        bit_n   = '0;
        state_n = rx_s ? IDLE : DATA;
      end else cnt_n = cnt + 1'b1;
      DATA: if (cnt == LAST) begin
        cnt_n   = '0;
        shift_n = {rx_s, shift[7:1]};
        bit_n   = bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
        if (bit_idx == 3'd7) state_n = PARITY;
`else
        if (bit_idx == 3'd7) state_n = STOP;
`endif
      end else cnt_n = cnt + 1'b1;
`ifdef UART_RX_PARITY_EN
      PARITY: if (cnt == LAST) begin
        cnt_n   = '0;
        pbad_n  = ^{shift, rx_s};
        state_n = STOP;
      end else cnt_n = cnt + 1'b1;
`endif
      STOP: if (cnt == LAST) begin
        cnt_n  = '0;
        perr_n = pbad;
        if (!rx_s) begin
          ferr_n  = 1'b1;
          state_n = WAIT_IDLE;
        end else begin
          state_n = IDLE;
          if (!pbad) begin
            // an ack this cycle frees the slot, so the new byte is not an overrun
            if (valid && !ack) ovr_n = 1'b1;
            else begin
              data_n  = shift;
              valid_n = 1'b1;
            end
          end
        end
      end else cnt_n = cnt + 1'b1;
      default: state_n = WAIT_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit; define UART_RX_PARITY_EN to match a parity build.
module tb_uart_rx;
  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT = 2 + CPB/2 + 10*CPB;
  logic par_flip = 1'b0;
`else
  localparam int LAT = 2 + CPB/2 + 9*CPB;
`endif

  logic clk = 1'b0, rst = 1'b0, rx = 1'b1, ack = 1'b0;
  logic [7:0] data;
  logic valid, busy, frame_err, overrun, parity_err;
  int n_cmp = 0, n_bad = 0;
  int fe_tot = 0, pe_tot = 0, ov_tot = 0, busy_tot = 0;

  always #5 clk = ~clk;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .rx(rx), .ack(ack), .data(data), .valid(valid),
    .busy(busy), .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err)
  );

  always @(negedge clk) begin
    fe_tot   += int'(frame_err);
    pe_tot   += int'(parity_err);
    ov_tot   += int'(overrun);
    busy_tot += int'(busy);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // caller sits on a negedge; leaves rx at the stop level
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^b) ^ par_flip;
    repeat (CPB) @(negedge clk);
`endif
    rx = stop;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!valid && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int fe0, ov0, bs0, pe0, lat;
    repeat (3) @(negedge clk);
    chk("rst_data", data, 8'h00);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_parity_err", parity_err, 0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // single byte with latency
    fork
      send_frame(8'h41, 1'b1);
      begin
        lat = 0;
        while (!valid && lat < 400) begin
          @(negedge clk);
          lat++;
        end
      end
    join
    chk("lat_in_window", (lat >= LAT - 1) && (lat <= LAT + 1), 1);
    chk("b1_data", data, 8'h41);
    chk("b1_valid", valid, 1);
    repeat (10) @(negedge clk);
    chk("b1_hold", valid, 1);
    pulse_ack();
    chk("b1_ack_clr", valid, 0);
    chk("b1_overrun", overrun, 0);

    // back-to-back stream
    fe0 = fe_tot; ov0 = ov_tot;
    fork
      for (int i = 0; i < 23; i++) send_frame(8'h41 + 8'(i), 1'b1);
      for (int j = 0; j < 23; j++) begin
        int n;
        wait_valid(400, n);
        chk("stream_timeout", n < 400, 1);
        chk("stream_data", data, 32'h41 + 32'(j));
        @(negedge clk);
        pulse_ack();
      end
    join
    chk("stream_frame_err", fe_tot - fe0, 0);
    chk("stream_overrun", ov_tot - ov0, 0);

    // short low glitch
    repeat (20) @(negedge clk);
    bs0 = busy_tot;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_busy_seen", busy_tot > bs0, 1);
    chk("glitch_busy_end", busy, 0);
    chk("glitch_valid", valid, 0);
    send_frame(8'h5A, 1'b1);
    chk("after_glitch_data", data, 8'h5A);
    chk("after_glitch_valid", valid, 1);
    pulse_ack();

    // bad stop bit, line held low afterwards
    fe0 = fe_tot;
    send_frame(8'h55, 1'b0);
    repeat (40) @(negedge clk);
    chk("ferr_busy_low_line", busy, 0);
    rx = 1'b1;
    repeat (20) @(negedge clk);
    chk("ferr_pulses", fe_tot - fe0, 1);
    chk("ferr_valid", valid, 0);
    chk("ferr_data_kept", data, 8'h5A);

    // overrun
    send_frame(8'h41, 1'b1);
    send_frame(8'h42, 1'b1);
    repeat (4) @(negedge clk);
    chk("ovr_data", data, 8'h41);
    chk("ovr_valid", valid, 1);
    chk("ovr_flag", overrun, 1);
    pulse_ack();
    chk("ovr_ack_valid", valid, 0);
    chk("ovr_ack_flag", overrun, 0);
    send_frame(8'h43, 1'b1);
    chk("ovr_next_data", data, 8'h43);
    chk("ovr_next_valid", valid, 1);
    chk("ovr_next_flag", overrun, 0);

    // reset in the middle of data bit 3 of 0x77, valid still set from 0x43
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (3*CPB) @(negedge clk);
    rx = 1'b0;
    repeat (CPB/2) @(negedge clk);
    chk("mid_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("arst_data", data, 8'h00);
    chk("arst_valid", valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_overrun", overrun, 0);
    chk("arst_frame_err", frame_err, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (200) @(negedge clk);
    chk("low_after_rst_valid", valid, 0);
    chk("low_after_rst_busy", busy, 0);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    send_frame(8'h5A, 1'b1);
    chk("post_rst_data", data, 8'h5A);
    chk("post_rst_valid", valid, 1);
    pulse_ack();

`ifdef UART_RX_PARITY_EN
    pe0 = pe_tot;
    par_flip = 1'b1;
    send_frame(8'h41, 1'b1);
    par_flip = 1'b0;
    repeat (4) @(negedge clk);
    chk("par_err_pulses", pe_tot - pe0, 1);
    chk("par_valid", valid, 0);
    chk("par_overrun", overrun, 0);
    send_frame(8'h3C, 1'b1);
    chk("par_good_data", data, 8'h3C);
    chk("par_good_valid", valid, 1);
    pulse_ack();
`else
    pe0 = pe_tot;
    repeat (2) @(negedge clk);
    chk("no_parity_err", pe_tot - pe0 + int'(parity_err), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver; counterpart to the team's uart_tx, sharing the same bit timing.
- Oversamples the asynchronous serial line with the system clock, qualifies start bits and samples each bit at mid-period.
- Presents each received byte on a level valid/ack handshake.
- Reports framing and overrun errors for the consumer (host logic or loopback checker).

Parameters:
- CLKS_PER_BIT, 868, clk cycles per bit (100 MHz / 115200); legal minimum 4.
- CNT_W, $clog2(CLKS_PER_BIT), width of the baud counter. Derived; do not override.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset, asynchronous, active-low: asserted when 0, released synchronously to clk.
- rx  in  1  serial line, idle high, asynchronous to clk.
- ack  in  1  consumer has taken data; one-cycle pulse or level.
- data  out  8  last accepted byte.
- valid  out  1  data holds an unconsumed byte.
- busy  out  1  a frame is in progress (state not IDLE/WAIT_IDLE).
- frame_err  out  1  one-cycle pulse when the stop bit is sampled 0.
- overrun  out  1  sticky; a good byte was dropped because valid was still 1.
- parity_err  out  1  one-cycle pulse on parity mismatch (see Optional Feature).

Behaviour:
- Reset values:
  - data=8'h00, valid=0, busy=0, frame_err=0, overrun=0, parity_err=0.
  - Synchronizer flops=1, counters=0, state=WAIT_IDLE.
- Input sync: rx passes a 2-flop synchronizer giving rx_s. All decisions use rx_s only.
- States:
  - WAIT_IDLE: stay until rx_s==1, then IDLE. Used after reset and after a framing error, so a low or mid-frame line never gets mis-framed.
  - IDLE: on rx_s==0, clear counter and go to START.
  - START: count to CLKS_PER_BIT/2-1. At mid-start, rx_s==1 is a false start: go to IDLE, no outputs change. rx_s==0 clears the counter and goes to DATA.
  - DATA: every CLKS_PER_BIT cycles sample rx_s. Shift right into an 8-bit shift register (LSB first, new bit enters bit 7). After the 8th sample go to STOP, or to PARITY when the feature is enabled.
  - STOP: after CLKS_PER_BIT cycles sample rx_s, i.e. mid-stop.
    - Sample 1 and valid==0: data<=shift, valid<=1.
    - Sample 1 and valid==1: byte discarded, overrun<=1.
    - After a good stop, go to IDLE immediately at mid-stop, ready for the next start edge.
    - Sample 0: frame_err pulses 1 cycle, byte discarded, valid/data untouched, go to WAIT_IDLE.
- Handshake:
  - valid stays 1 until a cycle with ack==1, which clears valid and overrun the next edge.
  - ack with valid==0 has no effect.
- Simultaneous events: ack in the same cycle a good byte completes loads the new byte with valid=1 and sets no overrun.
- Latency: valid rises 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT (±1) cycles after the rx falling edge.
- Reset mid-frame: every output returns to its reset value immediately (asynchronous). Reception resumes only after rx has been seen high.

Optional Feature:
- Macro UART_RX_PARITY_EN.
- Defined:
  - A PARITY state follows DATA and samples one extra bit CLKS_PER_BIT cycles after bit 7.
  - Even parity over data bits plus the parity bit is required.
  - On mismatch, parity_err pulses 1 cycle at the stop sample and the byte is discarded (no valid, no overrun). The frame still proceeds to STOP for framing.
- Undefined: no PARITY state, and parity_err is tied to 0.

Test Plan (CLKS_PER_BIT=16, 10 ns clk):
- Reset release with rx=1, send 8N1 0x41 → valid=1, data=8'h41 about 154 cycles after the start edge. valid holds until ack, then clears next cycle.
- Stream 0x41..0x57 back-to-back, acking 1 cycle after each valid → 23 bytes in order, frame_err=0, overrun=0.
- rx low for 4 cycles then high → busy pulses then returns to 0, valid stays 0, next real frame 0x5A received correctly.
- Frame 0x55 with stop bit 0 → frame_err 1-cycle pulse, valid=0. A start edge sent before rx returns high is ignored.
- Two frames 0x41, 0x42 with no ack → data=8'h41, valid=1, overrun=1. An ack clears both; the third frame 0x43 is received normally.
- Assert rst during DATA bit 3, release with rx low → all outputs 0. No reception until rx goes high; the subsequent 0x5A is received. With UART_RX_PARITY_EN, a wrong parity bit on 0x41 gives a parity_err pulse and valid=0.
